// File: rtl/btf_addsub.sv
// rtl/btf_addsub.sv - butterfly modular add/sub stage with optional halving
module btf_addsub #(
    parameter int          LOGQ    = 32,
    parameter logic [63:0] Q_VALUE = 64'd0,
    parameter int          OUT_REG = 1,
    parameter int          TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LOGQ-1:0]  q,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [LOGQ-1:0]  e,
    input  logic [LOGQ-1:0]  o,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [LOGQ-1:0]  x,
    output logic [LOGQ-1:0]  y,
    output logic [TAG_W-1:0] out_tag
);

    logic [LOGQ-1:0] w_qe;
    assign w_qe = (Q_VALUE != 64'd0) ? Q_VALUE[LOGQ-1:0] : q;

    // (v+m)/2 for odd v and odd m, rewritten so it never needs an extra bit
    function automatic logic [LOGQ-1:0] halve(input logic [LOGQ-1:0] v,
                                               input logic [LOGQ-1:0] m);
        return v[0] ? (v >> 1) + (m >> 1) + LOGQ'(1) : (v >> 1);
    endfunction

    logic             r1_valid;
    logic [LOGQ-1:0]  r1_e;
    logic [LOGQ-1:0]  r1_o;
    logic [1:0]       r1_mode;
    logic [TAG_W-1:0] r1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_e     <= '0;
            r1_o     <= '0;
            r1_mode  <= '0;
            r1_tag   <= '0;
        end else begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_e    <= e;
                r1_o    <= o;
                r1_mode <= mode;
                r1_tag  <= in_tag;
            end
        end
    end

    logic [LOGQ:0]   w_sum;
    logic [LOGQ:0]   w_dif;
    logic [LOGQ-1:0] w_sum_c;
    logic [LOGQ-1:0] w_dif_c;
    logic [LOGQ-1:0] w_a;
    logic [LOGQ-1:0] w_b;
    logic            w_halve;

    // Corrections are done modulo 2^LOGQ; the true result is < q so it fits
    assign w_sum   = {1'b0, r1_e} + {1'b0, r1_o};
    assign w_dif   = {1'b0, r1_e} - {1'b0, r1_o};
    assign w_sum_c = (w_sum >= {1'b0, w_qe}) ? w_sum[LOGQ-1:0] - w_qe : w_sum[LOGQ-1:0];
    assign w_dif_c = w_dif[LOGQ] ? w_dif[LOGQ-1:0] + w_qe : w_dif[LOGQ-1:0];
    assign w_a     = r1_mode[1] ? r1_e : w_sum_c;
    assign w_b     = r1_mode[1] ? r1_o : w_dif_c;
    assign w_halve = (r1_mode == 2'b01);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             r2_valid;
            logic             r2_halve;
            logic [LOGQ-1:0]  r2_a;
            logic [LOGQ-1:0]  r2_b;
            logic [TAG_W-1:0] r2_tag;
            logic             r3_valid;
            logic [LOGQ-1:0]  r3_x;
            logic [LOGQ-1:0]  r3_y;
            logic [TAG_W-1:0] r3_tag;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r2_valid <= 1'b0;
                    r2_halve <= 1'b0;
                    r2_a     <= '0;
                    r2_b     <= '0;
                    r2_tag   <= '0;
                    r3_valid <= 1'b0;
                    r3_x     <= '0;
                    r3_y     <= '0;
                    r3_tag   <= '0;
                end else begin
                    r2_valid <= r1_valid;
                    r3_valid <= r2_valid;
                    if (r1_valid) begin
                        r2_halve <= w_halve;
                        r2_a     <= w_a;
                        r2_b     <= w_b;
                        r2_tag   <= r1_tag;
                    end
                    if (r2_valid) begin
                        r3_x   <= r2_halve ? halve(r2_a, w_qe) : r2_a;
                        r3_y   <= r2_halve ? halve(r2_b, w_qe) : r2_b;
                        r3_tag <= r2_tag;
                    end
                end
            end

            assign out_valid = r3_valid;
            assign x         = r3_x;
            assign y         = r3_y;
            assign out_tag   = r3_tag;
        end else begin : g_no_out_reg
            logic             r2_valid;
            logic [LOGQ-1:0]  r2_x;
            logic [LOGQ-1:0]  r2_y;
            logic [TAG_W-1:0] r2_tag;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r2_valid <= 1'b0;
                    r2_x     <= '0;
                    r2_y     <= '0;
                    r2_tag   <= '0;
                end else begin
                    r2_valid <= r1_valid;
                    if (r1_valid) begin
                        r2_x   <= w_halve ? halve(w_a, w_qe) : w_a;
                        r2_y   <= w_halve ? halve(w_b, w_qe) : w_b;
                        r2_tag <= r1_tag;
                    end
                end
            end

            assign out_valid = r2_valid;
            assign x         = r2_x;
            assign y         = r2_y;
            assign out_tag   = r2_tag;
        end
    endgenerate

endmodule
